// File: rtl/spi_cmd_ctrl_pkg.sv
// Shared definitions for the SPI command controller: opcodes, FSM states
// and a saturating increment used by the error counter.
package spi_cmd_pkg;

    localparam logic [7:0] OP_WRITE = 8'hA0;
    localparam logic [7:0] OP_CLEAR = 8'hC0;
    localparam logic [7:0] OP_NOP   = 8'h00;

    typedef enum logic [2:0] {
        IDLE,
        OPC,
        ADDR,
        DATA,
        DISCARD
    } state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/spi_cmd_ctrl_reg_bank.sv
// NREGS x 8 configuration register bank with single write port and a
// whole-bank clear that overrides a simultaneous write.
module spi_reg_bank
    import spi_cmd_pkg::*;
#(
    parameter int unsigned NREGS   = 16,
    parameter int unsigned AW      = 4,
    parameter logic [7:0]  RST_VAL = 8'h00
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [7:0]         wr_data,
    input  logic               clear,
    output logic [NREGS*8-1:0] regs_flat
);

    logic [7:0] r_regs [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                r_regs[i] <= RST_VAL;
            end
        end else if (clear) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                r_regs[i] <= RST_VAL;
            end
        end else if (wr_en) begin
            r_regs[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        regs_flat = '0;
        for (int unsigned i = 0; i < NREGS; i++) begin
            regs_flat[i*8 +: 8] = r_regs[i];
        end
    end

endmodule

// File: rtl/spi_cmd_ctrl.sv
// Frame-level SPI command parser: opcode, address, then auto-incrementing
// data bytes into an owned register bank, with error reporting.
module spi_cmd_ctrl
    import spi_cmd_pkg::*;
#(
    parameter int unsigned NREGS   = 16,
    parameter int unsigned AW      = 4,
    parameter logic [7:0]  RST_VAL = 8'h00
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [7:0]         rx_byte,
    input  logic               rx_valid,
    input  logic               frame_active,
    output logic               reg_wr_en,
    output logic [AW-1:0]      reg_wr_addr,
    output logic [7:0]         reg_wr_data,
    output logic [NREGS*8-1:0] regs_flat,
    output logic               frame_done,
    output logic               err,
    output logic [7:0]         err_count,
    output logic               busy
);

    state_t          r_state;
    logic [AW-1:0]   r_ptr;
    logic            r_ovf;
    logic            r_wr_en;
    logic [AW-1:0]   r_wr_addr;
    logic [7:0]      r_wr_data;
    logic            r_clear;
    logic            r_frame_done;
    logic            r_err;
    logic [7:0]      r_err_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_ptr        <= '0;
            r_ovf        <= 1'b0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_clear      <= 1'b0;
            r_frame_done <= 1'b0;
            r_err        <= 1'b0;
            r_err_count  <= '0;
        end else begin
            r_wr_en      <= 1'b0;
            r_clear      <= 1'b0;
            r_frame_done <= 1'b0;
            r_err        <= 1'b0;

            // Frame end outranks any byte arriving in the same cycle.
            if (r_state != IDLE && !frame_active) begin
                r_state      <= IDLE;
                r_frame_done <= 1'b1;
                r_ptr        <= '0;
                r_ovf        <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (frame_active) begin
                            r_state <= OPC;
                        end
                    end
                    OPC: begin
                        if (rx_valid) begin
                            case (rx_byte)
                                OP_WRITE: r_state <= ADDR;
                                OP_CLEAR: begin
                                    r_clear <= 1'b1;
                                    r_state <= DISCARD;
                                end
                                OP_NOP:   r_state <= DISCARD;
                                default: begin
                                    r_err       <= 1'b1;
                                    r_err_count <= sat_inc8(r_err_count);
                                    r_state     <= DISCARD;
                                end
                            endcase
                        end
                    end
                    ADDR: begin
                        if (rx_valid) begin
                            if (32'(rx_byte) < NREGS) begin
                                r_ptr   <= rx_byte[AW-1:0];
                                r_state <= DATA;
                            end else begin
                                r_err       <= 1'b1;
                                r_err_count <= sat_inc8(r_err_count);
                                r_state     <= DISCARD;
                            end
                        end
                    end
                    DATA: begin
                        if (rx_valid) begin
                            if (r_ovf) begin
                                r_err       <= 1'b1;
                                r_err_count <= sat_inc8(r_err_count);
                                r_state     <= DISCARD;
                            end else begin
                                r_wr_en   <= 1'b1;
                                r_wr_addr <= r_ptr;
                                r_wr_data <= rx_byte;
                                // Last register: stay in DATA so the next byte is flagged, no wrap.
                                if (r_ptr == AW'(NREGS - 1)) begin
                                    r_ovf <= 1'b1;
                                end else begin
                                    r_ptr <= r_ptr + AW'(1);
                                end
                            end
                        end
                    end
                    DISCARD: begin
                        r_state <= DISCARD;
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    spi_reg_bank #(
        .NREGS   (NREGS),
        .AW      (AW),
        .RST_VAL (RST_VAL)
    ) u_bank (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (r_wr_en),
        .wr_addr   (r_wr_addr),
        .wr_data   (r_wr_data),
        .clear     (r_clear),
        .regs_flat (regs_flat)
    );

    assign reg_wr_en   = r_wr_en;
    assign reg_wr_addr = r_wr_addr;
    assign reg_wr_data = r_wr_data;
    assign frame_done  = r_frame_done;
    assign err         = r_err;
    assign err_count   = r_err_count;
    assign busy        = frame_active | r_wr_en;

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Directed self-checking bench for spi_cmd_ctrl (NREGS=16).
module tb_spi_cmd_ctrl;

    logic         clk;
    logic         rst_n;
    logic [7:0]   rx_byte;
    logic         rx_valid;
    logic         frame_active;
    logic         reg_wr_en;
    logic [3:0]   reg_wr_addr;
    logic [7:0]   reg_wr_data;
    logic [127:0] regs_flat;
    logic         frame_done;
    logic         err;
    logic [7:0]   err_count;
    logic         busy;

    int checks   = 0;
    int failures = 0;
    int n_wr     = 0;
    int n_err    = 0;
    int n_done   = 0;

    spi_cmd_ctrl #(
        .NREGS   (16),
        .AW      (4),
        .RST_VAL (8'h00)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_byte      (rx_byte),
        .rx_valid     (rx_valid),
        .frame_active (frame_active),
        .reg_wr_en    (reg_wr_en),
        .reg_wr_addr  (reg_wr_addr),
        .reg_wr_data  (reg_wr_data),
        .regs_flat    (regs_flat),
        .frame_done   (frame_done),
        .err          (err),
        .err_count    (err_count),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reg_wr_en)  n_wr++;
        if (err)        n_err++;
        if (frame_done) n_done++;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_byte  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic open_frame();
        frame_active = 1'b1;
        tick();
    endtask

    task automatic close_frame(input bit chk);
        frame_active = 1'b0;
        tick();
        if (chk) check("frame_done_pulse", frame_done, 1);
        tick();
    endtask

    function automatic logic [7:0] reg_at(input int i);
        return regs_flat[i*8 +: 8];
    endfunction

    int  s_wr, s_err, s_done;
    bit  any_strobe;

    initial begin
        rst_n        = 1'b0;
        rx_byte      = 8'h00;
        rx_valid     = 1'b0;
        frame_active = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Reset state and quiet idle
        check("rst_regs", regs_flat, 128'h0);
        check("rst_err_count", err_count, 0);
        check("rst_busy", busy, 0);
        any_strobe = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            any_strobe |= reg_wr_en | err | frame_done;
        end
        check("idle_no_strobes", any_strobe, 0);

        // Frame A0,03,11,22,33
        s_wr = n_wr; s_err = n_err; s_done = n_done;
        open_frame();
        check("busy_in_frame", busy, 1);
        send_byte(8'hA0);
        send_byte(8'h03);
        send_byte(8'h11);
        check("wr1_en", reg_wr_en, 1);
        check("wr1_addr", reg_wr_addr, 4'h3);
        check("wr1_data", reg_wr_data, 8'h11);
        check("wr1_reg_not_yet", reg_at(3), 8'h00);
        tick();
        check("wr1_reg", reg_at(3), 8'h11);
        check("wr1_en_one_cycle", reg_wr_en, 0);
        send_byte(8'h22);
        check("wr2_addr", reg_wr_addr, 4'h4);
        check("wr2_data", reg_wr_data, 8'h22);
        tick();
        check("wr2_reg", reg_at(4), 8'h22);
        send_byte(8'h33);
        check("wr3_addr", reg_wr_addr, 4'h5);
        tick();
        check("wr3_reg", reg_at(5), 8'h33);
        close_frame(1);
        check("f1_writes", n_wr - s_wr, 3);
        check("f1_errs", n_err - s_err, 0);
        check("f1_dones", n_done - s_done, 1);

        // Frame A0,0F,AA,BB: last register written, overflow byte errors
        s_wr = n_wr; s_err = n_err;
        open_frame();
        send_byte(8'hA0);
        send_byte(8'h0F);
        send_byte(8'hAA);
        check("ovf_last_addr", reg_wr_addr, 4'hF);
        send_byte(8'hBB);
        check("ovf_err", err, 1);
        check("ovf_no_write", reg_wr_en, 0);
        close_frame(1);
        check("ovf_err_count", err_count, 1);
        check("ovf_writes", n_wr - s_wr, 1);
        check("ovf_errs", n_err - s_err, 1);
        check("ovf_regs", regs_flat, 128'hAA000000_00000000_00003322_11000000);

        // Frame 5A,A0,01,FF: bad opcode, rest discarded
        s_wr = n_wr; s_err = n_err;
        open_frame();
        send_byte(8'h5A);
        check("badop_err", err, 1);
        send_byte(8'hA0);
        send_byte(8'h01);
        send_byte(8'hFF);
        close_frame(1);
        check("badop_errs", n_err - s_err, 1);
        check("badop_writes", n_wr - s_wr, 0);
        check("badop_err_count", err_count, 2);
        check("badop_regs", regs_flat, 128'hAA000000_00000000_00003322_11000000);

        // Frame C0: clear bank
        s_err = n_err;
        open_frame();
        send_byte(8'hC0);
        close_frame(1);
        check("clear_regs", regs_flat, 128'h0);
        check("clear_no_err", n_err - s_err, 0);

        // Frame A0,20: address out of range
        s_wr = n_wr;
        open_frame();
        send_byte(8'hA0);
        send_byte(8'h20);
        check("addr_oor_err", err, 1);
        close_frame(1);
        check("addr_oor_writes", n_wr - s_wr, 0);
        check("addr_oor_err_count", err_count, 3);

        // Empty frame
        s_done = n_done; s_err = n_err;
        open_frame();
        close_frame(1);
        check("empty_dones", n_done - s_done, 1);
        check("empty_errs", n_err - s_err, 0);

        // Byte coincident with frame end is dropped
        s_wr = n_wr;
        open_frame();
        send_byte(8'hA0);
        send_byte(8'h05);
        rx_byte      = 8'h99;
        rx_valid     = 1'b1;
        frame_active = 1'b0;
        tick();
        rx_valid = 1'b0;
        check("drop_no_wr", reg_wr_en, 0);
        check("drop_done", frame_done, 1);
        tick();
        check("drop_reg5", reg_at(5), 8'h00);
        check("drop_writes", n_wr - s_wr, 0);

        // Reset mid-frame with a write pending
        open_frame();
        send_byte(8'hA0);
        send_byte(8'h02);
        send_byte(8'h55);
        check("pre_rst_wr_en", reg_wr_en, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_wr_en", reg_wr_en, 0);
        check("mid_rst_wr_addr", reg_wr_addr, 0);
        check("mid_rst_wr_data", reg_wr_data, 0);
        check("mid_rst_err_count", err_count, 0);
        frame_active = 1'b0;
        tick();
        tick();
        check("mid_rst_regs", regs_flat, 128'h0);
        rst_n = 1'b1;
        tick();
        open_frame();
        send_byte(8'hA0);
        send_byte(8'h02);
        send_byte(8'h77);
        tick();
        check("post_rst_reg2", reg_at(2), 8'h77);
        close_frame(1);

        // Saturating error counter
        s_err = n_err;
        for (int i = 0; i < 255; i++) begin
            open_frame();
            send_byte(8'h5A);
            close_frame(0);
        end
        check("sat_at_255", err_count, 8'hFF);
        for (int i = 0; i < 5; i++) begin
            open_frame();
            send_byte(8'h5A);
            close_frame(0);
        end
        check("sat_hold", err_count, 8'hFF);
        check("sat_err_pulses", n_err - s_err, 260);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
